// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared grant encoding and lock defaults for the data-memory arbiter
package dmem_pkg;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_EXT = 1'b1
  } gnt_e;

  localparam int LOCK_MAX_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and saturated flag
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear has priority so a CPU grant always restarts the burst budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  assign sat_o = (cnt_q >= LIMIT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-cycle arbiter sharing data memory between CPU and loader port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       ext_req,
  input  logic       ext_we,
  input  logic       ext_lock,
  input  logic [7:0] ext_addr,
  input  logic [7:0] ext_wdata,
  output logic [7:0] ext_rdata,
  output logic       ext_ack,
  output logic       mem_mw,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  gnt_e last_gnt_q, last_gnt_d;
  logic lock_sat;
  logic lock_active;
  logic ext_wins;
  logic gnt_cpu;
  logic gnt_ext;
  logic lock_inc;
  logic lock_clr;

  assign lock_active = ext_lock & ~lock_sat;

  // EXT takes the cycle when alone, when its burst lock holds, or when the CPU went last.
  assign ext_wins = ext_req & (~cpu_req | lock_active | (last_gnt_q == GNT_CPU));

  // Grants are gated by reset so an access in flight when rst_n falls never commits.
  assign gnt_ext = rst_n & ext_wins;
  assign gnt_cpu = rst_n & cpu_req & ~ext_wins;

  assign lock_inc = gnt_ext & cpu_req & ext_lock;
  assign lock_clr = gnt_cpu | ~ext_lock;

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (LOCK_MAX)
  ) u_lock_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (lock_inc),
    .clr_i (lock_clr),
    .sat_o (lock_sat)
  );

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_cpu) begin
      last_gnt_d = GNT_CPU;
    end else if (gnt_ext) begin
      last_gnt_d = GNT_EXT;
    end
  end

  // Reset pointer is EXT so the CPU wins the first unlocked conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GNT_EXT;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    mem_mw    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    if (gnt_cpu) begin
      mem_mw    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_ext) begin
      mem_mw    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
  assign cpu_stall = cpu_req & ~gnt_cpu;
  assign ext_ack   = gnt_ext;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       ext_req;
  logic       ext_we;
  logic       ext_lock;
  logic [7:0] ext_addr;
  logic [7:0] ext_wdata;
  logic [7:0] ext_rdata;
  logic       ext_ack;
  logic       mem_mw;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [0:255];

  int n_cmp;
  int n_bad;

  dmem_arbiter #(.LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_lock  (ext_lock),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .mem_mw    (mem_mw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_mw) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic lk, input logic [7:0] a, input logic [7:0] d);
    ext_req = req; ext_we = we; ext_lock = lk; ext_addr = a; ext_wdata = d;
  endtask

  // {ext_ack, cpu_stall}: 2'b11 means EXT won against a waiting CPU, 2'b00 means CPU won.
  task automatic chk_gnt(input string tag, input logic exp_ext);
    chk(tag, {6'd0, ext_ack, cpu_stall}, exp_ext ? 8'h03 : 8'h00);
  endtask

  initial begin
    logic [9:0] burst_pat;
    logic [10:0] drop_pat;
    logic [10:0] drop_cpu;
    logic [10:0] drop_lock;
    n_cmp = 0;
    n_bad = 0;

    // Reset held with a CPU request pending
    rst_n = 1'b0;
    set_cpu(1'b1, 1'b1, 8'h10, 8'h5A);
    set_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    chk("rst_stall", {7'd0, cpu_stall}, 8'h01);
    chk("rst_mw",    {7'd0, mem_mw},    8'h00);
    chk("rst_ack",   {7'd0, ext_ack},   8'h00);
    chk("rst_addr",  mem_addr,          8'h00);
    chk("rst_wdata", mem_wdata,         8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // CPU write 0x10 <- 0x5A, then read it back
    #3;
    chk("cpuw_mw",    {7'd0, mem_mw},    8'h01);
    chk("cpuw_addr",  mem_addr,          8'h10);
    chk("cpuw_wdata", mem_wdata,         8'h5A);
    chk("cpuw_stall", {7'd0, cpu_stall}, 8'h00);
    tick();
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    #3;
    chk("cpur_data", cpu_rdata,         8'h5A);
    chk("cpur_mw",   {7'd0, mem_mw},    8'h00);
    tick();

    // Solo EXT: write 0x20 <- 0xC3, then read it back
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_ext(1'b1, 1'b1, 1'b0, 8'h20, 8'hC3);
    #3;
    chk("extw_ack",  {7'd0, ext_ack}, 8'h01);
    chk("extw_mw",   {7'd0, mem_mw},  8'h01);
    chk("extw_addr", mem_addr,        8'h20);
    tick();
    set_ext(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    #3;
    chk("extr_ack",   {7'd0, ext_ack},   8'h01);
    chk("extr_data",  ext_rdata,         8'hC3);
    chk("extr_stall", {7'd0, cpu_stall}, 8'h00);
    tick();

    // Conflict alternation, last grant was EXT: CPU, EXT, CPU, EXT
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    set_ext(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk_gnt($sformatf("alt%0d", i), (i % 2) == 1);
      chk($sformatf("alt%0d_addr", i), mem_addr, ((i % 2) == 1) ? 8'h20 : 8'h10);
      tick();
    end

    // Locked burst, counter clear, last grant EXT: EXTx4 CPU EXTx4 CPU
    ext_lock = 1'b1;
    burst_pat = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk_gnt($sformatf("burst%0d", i), burst_pat[9-i]);
      tick();
    end

    // Lock drop: 2 locked wins, solo EXT with lock low clears the count,
    // then a fresh full burst of 4, then unlocked alternation.
    drop_lock = 11'b11011111000;
    drop_cpu  = 11'b11011111111;
    drop_pat  = 11'b11111110101;
    for (int i = 0; i < 11; i++) begin
      cpu_req  = drop_cpu[10-i];
      ext_lock = drop_lock[10-i];
      #3;
      if (drop_cpu[10-i]) begin
        chk_gnt($sformatf("drop%0d", i), drop_pat[10-i]);
      end else begin
        chk($sformatf("drop%0d_ack", i), {7'd0, ext_ack}, 8'h01);
      end
      tick();
    end

    // Preload 0x30 <- 0x77 through the EXT port
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_ext(1'b1, 1'b1, 1'b0, 8'h30, 8'h77);
    #3;
    chk("pre30_ack", {7'd0, ext_ack}, 8'h01);
    tick();

    // Reset lands during a locked EXT write to 0x30 before the edge
    set_ext(1'b1, 1'b1, 1'b1, 8'h30, 8'hEE);
    #2;
    chk("mid_ack_pre", {7'd0, ext_ack}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_ack", {7'd0, ext_ack}, 8'h00);
    chk("mid_mw",  {7'd0, mem_mw},  8'h00);
    tick();
    rst_n = 1'b1;
    set_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_cpu(1'b1, 1'b0, 8'h30, 8'h00);
    #3;
    chk("mid_keep", cpu_rdata, 8'h77);
    tick();

    // Fresh reset pointer: CPU wins the first unlocked conflict
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ext(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    #3;
    chk_gnt("post_rst_cpu", 1'b0);
    tick();
    #3;
    chk_gnt("post_rst_ext", 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
